// File: rtl/bus_seq_pkg.sv
// Shared types, legal parameter ranges and request decoding for the bus
// sequencer's instruction fetch path.
package bus_seq_pkg;

  typedef enum logic [1:0] {
    FOP_INC,
    FOP_JMP,
    FOP_CALL,
    FOP_RET
  } fetch_op_e;

  localparam int ROM_LATENCY_MIN = 1;
  localparam int ROM_LATENCY_MAX = 4;
  localparam int STACK_DEPTH_MIN = 1;
  localparam int STACK_DEPTH_MAX = 16;

  // Qualifier priority: return beats call, call beats jump, jump beats increment.
  function automatic fetch_op_e decode_op(input logic ret_en,
                                          input logic call_en,
                                          input logic jmp_en);
    if (ret_en)       return FOP_RET;
    else if (call_en) return FOP_CALL;
    else if (jmp_en)  return FOP_JMP;
    else              return FOP_INC;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Bounded LIFO holding subroutine return addresses. Push wins over pop if
// both are requested; flush empties the stack without touching the storage.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           push_data_i,
  output logic [WIDTH-1:0]           top_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LVL_W-1:0] r_level;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_top_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_wr_idx  = IDX_W'(r_level);
  assign w_top_idx = IDX_W'(r_level - LVL_W'(1));
  assign w_do_push = push_i && !full_o && !flush_i;
  assign w_do_pop  = pop_i && !empty_o && !flush_i && !push_i;

  assign full_o  = (r_level == LVL_W'(DEPTH));
  assign empty_o = (r_level == '0);
  assign level_o = r_level;
  assign top_o   = r_mem[w_top_idx];

  // Write the pushed return address into the slot just above the current top.
  // NOTE: storage is deliberately not reset; r_level alone defines which
  // entries are valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_do_push) begin
      r_mem[w_wr_idx] <= push_data_i;
    end
  end

  // Track occupancy; reset and flush both empty the stack.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_level <= '0;
    end else if (w_do_push) begin
      r_level <= r_level + LVL_W'(1);
    end else if (w_do_pop) begin
      r_level <= r_level - LVL_W'(1);
    end
  end

endmodule

// File: rtl/rom_fetcher.sv
// Program counter and fetch sequencer for the instruction ROM: increments,
// relative jumps, call/return through ret_stack, and a read strobe pipeline
// that produces the data-ready pulse ROM_LATENCY cycles after each read.
module rom_fetcher
  import bus_seq_pkg::*;
#(
  parameter int ROM_DEPTH   = 256,
  parameter int JMP_WIDTH   = 8,
  parameter int ROM_LATENCY = 1,
  parameter int STACK_DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             load_start_i,
  input  logic [31:0]                      start_addr_i,
  input  logic                             read_next_i,
  input  logic                             jmp_en_i,
  input  logic                             call_en_i,
  input  logic                             ret_en_i,
  input  logic                             jmp_dir_up_i,
  input  logic [JMP_WIDTH-1:0]             jmp_value_i,
  output logic [31:0]                      rom_addr_o,
  output logic                             rom_rden_o,
  output logic                             rom_data_rdy_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_lvl_o,
  output logic                             stack_err_o
);

  localparam int ADDR_WIDTH = $clog2(ROM_DEPTH);

  // Elaboration-time rejection of illegal configurations.
  if (ROM_DEPTH < 2 || (ROM_DEPTH & (ROM_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "rom_fetcher: ROM_DEPTH must be a power of two >= 2");
  end
  if (ROM_LATENCY < ROM_LATENCY_MIN || ROM_LATENCY > ROM_LATENCY_MAX) begin : g_bad_latency
    $fatal(1, "rom_fetcher: ROM_LATENCY out of range");
  end
  if (STACK_DEPTH < STACK_DEPTH_MIN || STACK_DEPTH > STACK_DEPTH_MAX) begin : g_bad_stack
    $fatal(1, "rom_fetcher: STACK_DEPTH out of range");
  end

  logic [ADDR_WIDTH-1:0]  r_pc;
  logic                   r_err;
  logic [ROM_LATENCY:0]   r_req_sr;

  logic [ADDR_WIDTH-1:0]  w_pc_next;
  logic [ADDR_WIDTH-1:0]  w_pc_inc;
  logic [ADDR_WIDTH-1:0]  w_pc_target;
  logic [ADDR_WIDTH-1:0]  w_offset;
  logic [ADDR_WIDTH-1:0]  w_top;
  logic                   w_err_next;
  logic                   w_req;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_unused_addr_bits;
  fetch_op_e              w_op;

  // Only the low address bits select a ROM word.
  assign w_unused_addr_bits = ^start_addr_i[31:ADDR_WIDTH];

  assign w_op        = decode_op(ret_en_i, call_en_i, jmp_en_i);
  assign w_offset    = ADDR_WIDTH'(jmp_value_i);
  assign w_pc_inc    = r_pc + ADDR_WIDTH'(1);
  assign w_pc_target = jmp_dir_up_i ? (r_pc + w_offset) : (r_pc - w_offset);

  // Next pc, error flag, stack control and request pulse for this cycle.
  // NOTE: every output gets a default before any branch so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    w_pc_next  = r_pc;
    w_err_next = r_err;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_req      = 1'b0;
    if (load_start_i) begin
      w_pc_next  = start_addr_i[ADDR_WIDTH-1:0];
      w_err_next = 1'b0;
      w_req      = 1'b1;
    end else if (read_next_i) begin
      w_req = 1'b1;
      case (w_op)
        FOP_JMP: w_pc_next = w_pc_target;
        FOP_CALL: begin
          if (!w_full) begin
            w_push    = 1'b1;
            w_pc_next = w_pc_target;
          end else begin
            w_err_next = 1'b1;
          end
        end
        FOP_RET: begin
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_pc_next = w_top;
          end else begin
            w_err_next = 1'b1;
          end
        end
        default: w_pc_next = w_pc_inc;
      endcase
    end
  end

  // Register pc, sticky error and the request shift register; reset flushes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc     <= '0;
      r_err    <= 1'b0;
      r_req_sr <= '0;
    end else begin
      r_pc     <= w_pc_next;
      r_err    <= w_err_next;
      r_req_sr <= {r_req_sr[ROM_LATENCY-1:0], w_req};
    end
  end

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_ret_stack (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (load_start_i),
    .push_i      (w_push),
    .pop_i       (w_pop),
    .push_data_i (w_pc_inc),
    .top_o       (w_top),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .level_o     (stack_lvl_o)
  );

  assign rom_addr_o     = 32'(r_pc);
  assign rom_rden_o     = r_req_sr[0];
  assign rom_data_rdy_o = r_req_sr[ROM_LATENCY];
  assign stack_err_o    = r_err;

endmodule

// File: tb/tb_rom_fetcher.sv
// Bench for rom_fetcher: two instances (ROM_LATENCY 2 and 4) share one
// stimulus stream and are compared with a queue-based reference model.
module tb_rom_fetcher;

  localparam int DEPTH = 16;
  localparam int SD    = 2;
  localparam int LAT_A = 2;
  localparam int LAT_B = 4;

  logic        clk = 1'b0;
  logic        rst_i, load_start_i, read_next_i, jmp_en_i, call_en_i, ret_en_i, jmp_dir_up_i;
  logic [31:0] start_addr_i;
  logic [7:0]  jmp_value_i;

  logic [31:0] addr_a, addr_b;
  logic        rden_a, rden_b, rdy_a, rdy_b, err_a, err_b;
  logic [1:0]  lvl_a, lvl_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int m_pc = 0;
  int m_stack[$];
  bit m_err = 1'b0;
  bit m_hist[$];   // m_hist[k] = request accepted k+1 edges ago

  always #5 clk = ~clk;

  rom_fetcher #(.ROM_DEPTH(DEPTH), .JMP_WIDTH(8), .ROM_LATENCY(LAT_A), .STACK_DEPTH(SD)) u_dut_a (
    .clk_i(clk), .rst_i(rst_i), .load_start_i(load_start_i), .start_addr_i(start_addr_i),
    .read_next_i(read_next_i), .jmp_en_i(jmp_en_i), .call_en_i(call_en_i), .ret_en_i(ret_en_i),
    .jmp_dir_up_i(jmp_dir_up_i), .jmp_value_i(jmp_value_i), .rom_addr_o(addr_a),
    .rom_rden_o(rden_a), .rom_data_rdy_o(rdy_a), .stack_lvl_o(lvl_a), .stack_err_o(err_a));

  rom_fetcher #(.ROM_DEPTH(DEPTH), .JMP_WIDTH(8), .ROM_LATENCY(LAT_B), .STACK_DEPTH(SD)) u_dut_b (
    .clk_i(clk), .rst_i(rst_i), .load_start_i(load_start_i), .start_addr_i(start_addr_i),
    .read_next_i(read_next_i), .jmp_en_i(jmp_en_i), .call_en_i(call_en_i), .ret_en_i(ret_en_i),
    .jmp_dir_up_i(jmp_dir_up_i), .jmp_value_i(jmp_value_i), .rom_addr_o(addr_b),
    .rom_rden_o(rden_b), .rom_data_rdy_o(rdy_b), .stack_lvl_o(lvl_b), .stack_err_o(err_b));

  function automatic bit exp_pulse(input int k);
    return (m_hist.size() > k) ? m_hist[k] : 1'b0;
  endfunction

  // One clock cycle: drive at the falling edge, update the model at the
  // rising edge, return at the next falling edge where outputs are stable.
  task automatic cyc(input bit rst, input bit ld, input bit rn, input bit jmp, input bit call,
                     input bit ret, input bit up, input int val, input int start);
    bit req;
    int off, tgt;
    rst_i = rst; load_start_i = ld; read_next_i = rn; jmp_en_i = jmp; call_en_i = call;
    ret_en_i = ret; jmp_dir_up_i = up; jmp_value_i = 8'(val); start_addr_i = 32'(start);
    @(posedge clk);
    req = 1'b0;
    off = (val & 255) % DEPTH;
    tgt = up ? (m_pc + off) % DEPTH : (m_pc + DEPTH - off) % DEPTH;
    if (rst) begin
      m_pc = 0; m_stack.delete(); m_err = 1'b0; m_hist.delete();
    end else if (ld) begin
      m_pc = start & (DEPTH - 1); m_stack.delete(); m_err = 1'b0; req = 1'b1;
    end else if (rn) begin
      req = 1'b1;
      if (ret) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else m_err = 1'b1;
      end else if (call) begin
        if (m_stack.size() < SD) begin
          m_stack.push_back((m_pc + 1) % DEPTH);
          m_pc = tgt;
        end else m_err = 1'b1;
      end else if (jmp) m_pc = tgt;
      else m_pc = (m_pc + 1) % DEPTH;
    end
    m_hist.push_front(req);
    if (m_hist.size() > 8) void'(m_hist.pop_back());
    @(negedge clk);
    rst_i = 0; load_start_i = 0; read_next_i = 0; jmp_en_i = 0; call_en_i = 0; ret_en_i = 0;
  endtask

  task automatic idle();             cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);     endtask
  task automatic do_load(input int s); cyc(0, 1, 0, 0, 0, 0, 0, 0, s);   endtask
  task automatic do_inc();           cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);     endtask
  task automatic do_jmp(input bit up, input int v);  cyc(0, 0, 1, 1, 0, 0, up, v, 0); endtask
  task automatic do_call(input bit up, input int v); cyc(0, 0, 1, 0, 1, 0, up, v, 0); endtask
  task automatic do_ret();           cyc(0, 0, 1, 0, 0, 1, 0, 0, 0);     endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1, 1, 1, 3, 7);
    n_tests++;
    if ({addr_a, addr_b, rden_a, rden_b, rdy_a, rdy_b, lvl_a, lvl_b, err_a, err_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr %0d/%0d rden %b/%b rdy %b/%b lvl %0d/%0d err %b/%b required all 0",
               addr_a, addr_b, rden_a, rden_b, rdy_a, rdy_b, lvl_a, lvl_b, err_a, err_b);
    end
  endtask

  task automatic test_seq_wrap();
    int exp_addr[4] = '{14, 15, 0, 1};
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) do_load(14); else do_inc();
      n_tests++;
      if (addr_a !== 32'(exp_addr[i]) || addr_b !== 32'(exp_addr[i]) || rden_a !== 1'b1 ||
          rdy_a !== (i >= 2) || rdy_b !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_wrap[%0d]: got addr %0d rden %b rdy_a %b rdy_b %b required addr %0d rden 1 rdy_a %b rdy_b 0",
                 i, addr_a, rden_a, rdy_a, rdy_b, exp_addr[i], i >= 2);
      end
    end
    for (int j = 0; j < 5; j++) begin
      idle();
      n_tests++;
      if (rden_a !== 1'b0 || rdy_a !== (j < 2) || rdy_b !== (j < 4)) begin
        n_fail++;
        $display("FAIL seq_drain[%0d]: got rden %b rdy_a %b rdy_b %b required rden 0 rdy_a %b rdy_b %b",
                 j, rden_a, rdy_a, rdy_b, j < 2, j < 4);
      end
    end
  endtask

  task automatic test_jumps();
    do_load(5);
    do_jmp(1, 9);
    n_tests++;
    if (addr_a !== 32'd14 || addr_b !== 32'd14) begin
      n_fail++; $display("FAIL jump_up: got %0d required 14", addr_a);
    end
    do_jmp(0, 20);
    n_tests++;
    if (addr_a !== 32'd10 || addr_b !== 32'd10) begin
      n_fail++; $display("FAIL jump_down_wrap: got %0d required 10", addr_a);
    end
  endtask

  task automatic test_nested_calls();
    int exp_pc[4]  = '{13, 9, 14, 4};
    int exp_lvl[4] = '{1, 2, 1, 0};
    do_load(3);
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: do_call(1, 10);
        1: do_call(0, 4);
        default: do_ret();
      endcase
      n_tests++;
      if (addr_a !== 32'(exp_pc[i]) || lvl_a !== 2'(exp_lvl[i]) || lvl_b !== 2'(exp_lvl[i]) ||
          err_a !== 1'b0) begin
        n_fail++;
        $display("FAIL nested_call[%0d]: got pc %0d lvl %0d err %b required pc %0d lvl %0d err 0",
                 i, addr_a, lvl_a, err_a, exp_pc[i], exp_lvl[i]);
      end
    end
  endtask

  task automatic test_overflow_underflow();
    do_load(3);
    do_call(1, 10);
    do_call(0, 4);
    do_call(1, 1);
    n_tests++;
    if (addr_a !== 32'd9 || err_a !== 1'b1 || err_b !== 1'b1 || rden_a !== 1'b1 || lvl_a !== 2'd2) begin
      n_fail++;
      $display("FAIL overflow: got pc %0d err %b rden %b lvl %0d required pc 9 err 1 rden 1 lvl 2",
               addr_a, err_a, rden_a, lvl_a);
    end
    do_load(0);
    n_tests++;
    if (addr_a !== 32'd0 || err_a !== 1'b0 || lvl_a !== 2'd0) begin
      n_fail++;
      $display("FAIL load_clears_err: got pc %0d err %b lvl %0d required pc 0 err 0 lvl 0", addr_a, err_a, lvl_a);
    end
    do_ret();
    n_tests++;
    if (addr_a !== 32'd0 || err_a !== 1'b1 || rden_a !== 1'b1 || lvl_a !== 2'd0) begin
      n_fail++;
      $display("FAIL underflow: got pc %0d err %b rden %b lvl %0d required pc 0 err 1 rden 1 lvl 0",
               addr_a, err_a, rden_a, lvl_a);
    end
    idle();
    n_tests++;
    if (err_a !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got %b required 1", err_a);
    end
  endtask

  task automatic test_priority();
    do_load(3);
    do_call(1, 1);
    cyc(0, 1, 1, 0, 1, 0, 1, 1, 32'hFFFF_FFF7);
    n_tests++;
    if (addr_a !== 32'd7 || lvl_a !== 2'd0) begin
      n_fail++; $display("FAIL load_over_call: got pc %0d lvl %0d required pc 7 lvl 0", addr_a, lvl_a);
    end
    do_call(1, 2);
    cyc(0, 0, 1, 1, 1, 1, 1, 5, 0);
    n_tests++;
    if (addr_a !== 32'd8 || lvl_a !== 2'd0 || err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL ret_priority: got pc %0d lvl %0d err %b required pc 8 lvl 0 err 0", addr_a, lvl_a, err_a);
    end
    cyc(0, 0, 0, 1, 1, 1, 1, 5, 0);
    n_tests++;
    if (addr_a !== 32'd8 || lvl_a !== 2'd0 || rden_a !== 1'b0 || err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL qualifiers_alone: got pc %0d lvl %0d rden %b err %b required pc 8 lvl 0 rden 0 err 0",
               addr_a, lvl_a, rden_a, err_a);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) idle();
    do_load(6);
    do_inc();
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 7; j++) begin
      n_tests++;
      if ({addr_a, addr_b, rden_a, rden_b, rdy_a, rdy_b, lvl_a, err_a} !== '0) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got addr %0d rden %b rdy_a %b rdy_b %b lvl %0d err %b required all 0",
                 j, addr_a, rden_a, rdy_a, rdy_b, lvl_a, err_a);
      end
      idle();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(99) == 0, $urandom_range(15) == 0, $urandom_range(3) != 0,
          $urandom_range(2) == 0, $urandom_range(2) == 0, $urandom_range(2) == 0,
          $urandom_range(1) == 1, int'($urandom_range(255)), int'($urandom()));
      n_tests++;
      if (addr_a !== 32'(m_pc) || addr_b !== 32'(m_pc) || lvl_a !== 2'(m_stack.size()) ||
          lvl_b !== 2'(m_stack.size()) || err_a !== m_err || err_b !== m_err ||
          rden_a !== exp_pulse(0) || rden_b !== exp_pulse(0) ||
          rdy_a !== exp_pulse(LAT_A) || rdy_b !== exp_pulse(LAT_B)) begin
        n_fail++;
        $display("FAIL random[%0d]: got pc %0d/%0d lvl %0d err %b rden %b rdy %b/%b required pc %0d lvl %0d err %b rden %b rdy %b/%b",
                 i, addr_a, addr_b, lvl_a, err_a, rden_a, rdy_a, rdy_b, m_pc, m_stack.size(), m_err,
                 exp_pulse(0), exp_pulse(LAT_A), exp_pulse(LAT_B));
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; load_start_i = 1'b0; read_next_i = 1'b0; jmp_en_i = 1'b0; call_en_i = 1'b0;
    ret_en_i = 1'b0; jmp_dir_up_i = 1'b0; jmp_value_i = '0; start_addr_i = '0;
    @(negedge clk);
    test_reset();
    test_seq_wrap();
    test_jumps();
    test_nested_calls();
    test_overflow_underflow();
    test_priority();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
